// File: rtl/acc_frame_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : acc_frame_fifo
//  Brief    : Synchronous FIFO buffering completed accumulator frame sums.
//             A push into a full FIFO with no simultaneous pop is dropped.
//             Every drop sets a sticky overflow flag and bumps a saturating
//             8-bit drop counter.
//             The head entry is shown on out_data, which is forced to zero
//             while the FIFO is empty.
//  Options  : ACC_FRAME_AVG_EN - when defined, each entry is stored as
//             in_sum >> 3 (mean of an 8-sample frame), zero-extended.
//  Revision : 1.0 - initial release
// ============================================================================
module acc_frame_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 13
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [DW-1:0]            in_sum,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DW-1:0]            out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    // Pointer width; occupancy needs one extra bit to represent DEPTH itself.
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] c_FULL_COUNT = CW'(DEPTH);
    localparam logic [7:0]    c_DROP_MAX   = 8'hFF;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic [7:0]    r_drop_cnt;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic [DW-1:0] w_wdata;

    // Entry transform: either the raw frame sum or its 8-sample average.
`ifdef ACC_FRAME_AVG_EN
    assign w_wdata = in_sum >> 3;
    // The three discarded LSBs are intentionally unused in this build.
    logic w_unused_lsbs;
    assign w_unused_lsbs = &{1'b0, in_sum[2:0]};
`else
    assign w_wdata = in_sum;
`endif

    // Status decoded from occupancy.
    assign w_full  = (r_count == c_FULL_COUNT);
    assign w_empty = (r_count == '0);

    // Handshakes. A pop frees a slot, so a push is accepted even when full
    // if the head leaves in the same cycle. Otherwise a full FIFO drops.
    assign w_pop  = !w_empty && out_ready;
    assign w_push = in_valid && (!w_full || w_pop);
    assign w_drop = in_valid && w_full && !w_pop;

    // Storage array: no reset needed, stale contents are masked by empty.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= w_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy: a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Drop bookkeeping: sticky flag plus an 8-bit counter that saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != c_DROP_MAX) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    // Output view. The head is read from storage only, never from in_sum,
    // so there is no same-cycle bypass. It is held while out_ready is low.
    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_acc_frame_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_acc_frame_fifo
//  Brief    : Directed self-checking bench for acc_frame_fifo (DEPTH=4, DW=13).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_acc_frame_fifo;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [12:0] in_sum;
    logic        out_ready;
    logic        out_valid;
    logic [12:0] out_data;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;
    logic [7:0]  drop_cnt;

    int n_cmp;
    int n_fail;

    acc_frame_fifo #(.DEPTH(4), .DW(13)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_sum    (in_sum),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Value expected to come out for a given pushed sum.
    function automatic logic [12:0] stored(input logic [12:0] v);
`ifdef ACC_FRAME_AVG_EN
        return v >> 3;
`else
        return v;
`endif
    endfunction

    // One clock; outputs are then sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input int base, input int inc);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_sum   = 13'(base + i * inc);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_sum = '0;
        step();
        step();
        reset = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %0b want 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %0b want 0", full); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_cmp++; if (out_data !== 13'd0) begin n_fail++; $display("FAIL reset_out_data got %0d want 0", out_data); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %0b want 0", overflow); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
    endtask

    task automatic test_basic();
        logic [12:0] exp_v;
`ifdef ACC_FRAME_AVG_EN
        exp_v = 13'd184;
`else
        exp_v = 13'd1475;
`endif
        out_ready = 1'b1; in_valid = 1'b1; in_sum = 13'd1475;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_no_bypass got %0b want 0", out_valid); end
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid got %0b want 1", out_valid); end
        n_cmp++; if (out_data !== exp_v) begin n_fail++; $display("FAIL basic_out_data got %0d want %0d", out_data, exp_v); end
        n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL basic_count got %0d want 1", count); end
        step();
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty_after_pop got %0b want 1", empty); end
        n_cmp++; if (out_data !== 13'd0) begin n_fail++; $display("FAIL basic_data_zero got %0d want 0", out_data); end
        out_ready = 1'b0;
    endtask

    task automatic test_fill_drop();
        out_ready = 1'b0;
        push_n(4, 100, 100);
        n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %0b want 1", full); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_no_overflow got %0b want 0", overflow); end
        push_n(1, 500, 0);
        n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL drop_count got %0d want 4", count); end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL drop_overflow got %0b want 1", overflow); end
        n_cmp++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL drop_cnt got %0d want 1", drop_cnt); end
        // Head is held while the consumer stalls.
        step();
        n_cmp++; if (out_data !== stored(13'd100)) begin n_fail++; $display("FAIL hold_data got %0d want %0d", out_data, stored(13'd100)); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_data !== stored(13'(100 * (i + 1)))) begin
                n_fail++; $display("FAIL fill_readback[%0d] got %0d want %0d", i, out_data, stored(13'(100 * (i + 1))));
            end
            step();
        end
        out_ready = 1'b0;
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fill_drained got %0b want 1", empty); end
    endtask

    task automatic test_full_push_pop();
        logic [12:0] order [4];
        order[0] = 13'd200; order[1] = 13'd300; order[2] = 13'd400; order[3] = 13'd600;
        out_ready = 1'b0;
        push_n(4, 100, 100);
        in_valid = 1'b1; in_sum = 13'd600; out_ready = 1'b1;
        n_cmp++; if (out_data !== stored(13'd100)) begin n_fail++; $display("FAIL fpp_head got %0d want %0d", out_data, stored(13'd100)); end
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL fpp_count got %0d want 4", count); end
        n_cmp++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL fpp_drop_cnt got %0d want 1", drop_cnt); end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fpp_overflow got %0b want 1", overflow); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_data !== stored(order[i])) begin
                n_fail++; $display("FAIL fpp_order[%0d] got %0d want %0d", i, out_data, stored(order[i]));
            end
            step();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [12:0] q [$];
        int pushed = 0;
        int popped = 0;
        bit do_pop;
        for (int i = 0; i < 80 && popped < 10; i++) begin
            out_ready = ((i % 4) == 1) || ((i % 7) == 3) || (i > 40);
            in_valid  = (pushed < 10) && ((i % 3) != 2) && (q.size() < 4 || out_ready);
            in_sum    = 13'(25 * (pushed + 1));
            do_pop    = (q.size() > 0) && out_ready;
            n_cmp++;
            if (out_valid !== (q.size() > 0)) begin
                n_fail++; $display("FAIL wrap_valid[%0d] got %0b want %0b", i, out_valid, q.size() > 0);
            end
            if (do_pop) begin
                n_cmp++;
                if (out_data !== stored(q[0])) begin
                    n_fail++; $display("FAIL wrap_data[%0d] got %0d want %0d", popped, out_data, stored(q[0]));
                end
                void'(q.pop_front());
                popped++;
            end
            if (in_valid) begin
                q.push_back(in_sum);
                pushed++;
            end
            step();
            n_cmp++;
            if (count !== 3'(q.size()) || count > 3'd4) begin
                n_fail++; $display("FAIL wrap_count[%0d] got %0d want %0d", i, count, q.size());
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++; if (popped != 10) begin n_fail++; $display("FAIL wrap_timeout popped %0d want 10", popped); end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1; step(); reset = 1'b0;
        out_ready = 1'b0;
        push_n(4, 10, 10);
        push_n(5, 999, 0);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL mid_setup_count got %0d want 3", count); end
        n_cmp++; if (drop_cnt !== 8'd5) begin n_fail++; $display("FAIL mid_setup_drop got %0d want 5", drop_cnt); end
        reset = 1'b1; in_valid = 1'b1; in_sum = 13'd777; out_ready = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL mid_count got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL mid_empty got %0b want 1", empty); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid got %0b want 0", out_valid); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_drop_cnt got %0d want 0", drop_cnt); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_overflow got %0b want 0", overflow); end
        push_n(1, 75, 0);
        n_cmp++; if (out_data !== stored(13'd75)) begin n_fail++; $display("FAIL mid_push75 got %0d want %0d", out_data, stored(13'd75)); end
        n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL mid_push75_count got %0d want 1", count); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
    endtask

    task automatic test_saturation();
        out_ready = 1'b0;
        push_n(4, 1, 1);
        in_valid = 1'b1; in_sum = 13'd8191;
        for (int i = 0; i < 300; i++) begin
            step();
            if (i == 254) begin
                n_cmp++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_reach got %0d want 255", drop_cnt); end
            end
        end
        in_valid = 1'b0;
        n_cmp++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_drop_cnt got %0d want 255", drop_cnt); end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL sat_overflow got %0b want 1", overflow); end
        n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL sat_count got %0d want 4", count); end
        n_cmp++; if (out_data !== stored(13'd1)) begin n_fail++; $display("FAIL sat_head got %0d want %0d", out_data, stored(13'd1)); end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        reset = 1'b1; in_valid = 1'b0; in_sum = '0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_fill_drop();
        test_full_push_pop();
        test_wrap();
        test_reset_mid();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/acc_frame_fifo.md
ACC_FRAME_FIFO -- requirements
Module: acc_frame_fifo

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- DW, 13, data width; matches the accumulator sum width.
REQ-002 The block SHALL have these ports (name, direction, width, meaning), one per line:
- clk, input, 1, single clock; all state updates on its rising edge.
- reset, input, 1, synchronous, active-high.
- in_valid, input, 1, frame sum offered on in_sum this cycle.
- in_sum, input, DW, completed accumulator frame sum.
- out_ready, input, 1, consumer accepts out_data this cycle.
- out_valid, output, 1, out_data holds a valid entry.
- out_data, output, DW, head-of-FIFO frame result.
- count, output, log2(DEPTH)+1, current occupancy.
- full, output, 1, count == DEPTH.
- empty, output, 1, count == 0.
- overflow, output, 1, sticky flag: a frame was dropped.
- drop_cnt, output, 8, number of frames dropped, saturating.

Function
REQ-003 Push SHALL occur when in_valid=1 and either (full=0) or (full=1 with a pop in the same cycle).
REQ-004 Pop SHALL occur when out_valid=1 and out_ready=1.
REQ-005 out_valid SHALL equal !empty; out_data SHALL present the oldest entry, with no combinational path from in_sum.
REQ-006 Latency: a push into an empty FIFO SHALL show out_valid=1 on the next cycle; there is no same-cycle bypass.
REQ-007 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order, including when count is 0 (pop is not possible) or DEPTH.
REQ-008 Write and read pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-009 Drop rule: if in_valid=1, full=1 and no pop occurs, the sum SHALL be discarded. On a drop:
- overflow SHALL be set to 1 and held until reset.
- drop_cnt SHALL increment, saturating at 255.
REQ-010 out_data SHALL hold its value while out_valid=1 and out_ready=0.
REQ-011 While empty, out_data SHALL be 0.
REQ-012 in_sum SHALL be stored unmodified, apart from the transform defined in REQ-016.

Reset
REQ-013 With reset=1 at a clk edge, the block SHALL clear:
- pointers and count to 0.
- out_valid and out_data to 0.
- overflow to 0 and drop_cnt to 0.
- full to 0 and empty to 1.
REQ-014 Reset SHALL take priority over a simultaneous push or pop; in-flight entries SHALL be lost.
REQ-015 Storage contents need not be cleared, but SHALL be unobservable after reset.

Configuration
REQ-016 Macro ACC_FRAME_AVG_EN:
- Defined: each pushed entry SHALL be in_sum >> 3 (frame average over 8 samples), zero-extended to DW.
- Undefined: each pushed entry SHALL be in_sum unchanged.
- All other behaviour SHALL be identical in both builds.

Verification
REQ-017 Basic push and pop:
- Stimulus: reset, then push 1475 with out_ready=1.
- Response: out_valid=1 and out_data=1475 one cycle later; empty=1 the cycle after the pop.
- With ACC_FRAME_AVG_EN defined: out_data=184.
REQ-018 Fill and drop:
- Stimulus: out_ready=0; push 100, 200, 300, 400, 500.
- Response: full=1 after the fourth push; 500 dropped; overflow=1; drop_cnt=1; outputs read back 100, 200, 300, 400 in order.
REQ-019 Full with simultaneous push and pop:
- Stimulus: FIFO full with 100..400; push 600 with out_ready=1.
- Response: 100 popped; count stays 4; overflow unchanged; order afterwards is 200, 300, 400, 600.
REQ-020 Pointer wrap:
- Stimulus: push and pop 10 sums (25, 50, ..., 250), interleaved irregularly.
- Response: every value emerges once, in order; count never exceeds 4.
REQ-021 Reset mid-operation:
- Stimulus: assert reset with count=3 and drop_cnt=5.
- Response: next cycle count=0, empty=1, out_valid=0, drop_cnt=0, overflow=0; a following push of 75 emerges as 75.
REQ-022 Drop-counter saturation:
- Stimulus: hold full with out_ready=0 and in_valid=1 for 300 cycles.
- Response: drop_cnt=255; overflow=1.
